// File: rtl/axi_crc_sequencer.sv
// axi_crc_sequencer: AXI master that writes a rotating seed pattern into the
// register slave, reads back its XOR-CRC location and compares it against a
// locally accumulated XOR. It reports pass, response errors and watchdog aborts.
module axi_crc_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_COUNT      = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] seed_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic                  resp_err_o,
    output logic                  timeout_o,
    output logic [DATA_WIDTH-1:0] crc_o,
    output logic [3:0]            awid_o,
    output logic [3:0]            awlen_o,
    output logic [2:0]            awsize_o,
    output logic [1:0]            awburst_o,
    output logic [ADDR_WIDTH-1:0] awaddr_o,
    output logic                  awvalid_o,
    input  logic                  awready_i,
    output logic [3:0]            wid_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [3:0]            wstrb_o,
    output logic                  wlast_o,
    output logic                  wvalid_o,
    input  logic                  wready_i,
    input  logic [3:0]            bid_i,
    input  logic [1:0]            bresp_i,
    input  logic                  bvalid_i,
    output logic                  bready_o,
    output logic [3:0]            arid_o,
    output logic [ADDR_WIDTH-1:0] araddr_o,
    output logic                  arvalid_o,
    input  logic                  arready_i,
    input  logic [3:0]            rid_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic                  rlast_i,
    input  logic                  rvalid_i,
    output logic                  rready_o
);

    localparam int IDX_W = 6;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);
    localparam logic [ADDR_WIDTH-1:0] CRC_ADDR = ADDR_WIDTH'(REG_COUNT * 4);

    typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA, FINISH} state_t;

    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      idx_next;
    logic [DATA_WIDTH-1:0] expected;
    logic [DATA_WIDTH-1:0] pat_rot;
    logic [WD_W-1:0]       wd;
    logic                  active;
    logic                  wd_expired;
    logic                  aw_pending;
    logic                  w_pending;
    logic                  unused_ok;

    // Single-beat, full-word, incrementing bursts with a single ID.
    assign awid_o    = 4'd0;
    assign wid_o     = 4'd0;
    assign arid_o    = 4'd0;
    assign awlen_o   = 4'd0;
    assign awsize_o  = 3'b010;
    assign awburst_o = 2'b01;
    assign wstrb_o   = 4'hF;
    assign wlast_o   = 1'b1;

    // IDs and rlast carry no information for single-beat single-ID traffic.
    assign unused_ok = ^{bid_i, rid_i, rlast_i};

    // wdata_o doubles as the rotate register: the next word is it rotated left by one.
    assign pat_rot    = {wdata_o[DATA_WIDTH-2:0], wdata_o[DATA_WIDTH-1]};
    assign idx_next   = idx + 1'b1;
    assign active     = (state == WRITE) || (state == WRESP) ||
                        (state == RADDR) || (state == RDATA);
    assign wd_expired = (wd == WD_W'(TIMEOUT_CYCLES - 1));
    // A channel still owes a handshake if its valid is up and not accepted this cycle.
    assign aw_pending = awvalid_o && !awready_i;
    assign w_pending  = wvalid_o && !wready_i;

    // Pass sequencer: all outputs registered; watchdog cleared on every state change.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state      <= IDLE;
            idx        <= '0;
            expected   <= '0;
            wd         <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            pass_o     <= 1'b0;
            resp_err_o <= 1'b0;
            timeout_o  <= 1'b0;
            crc_o      <= '0;
            awaddr_o   <= '0;
            wdata_o    <= '0;
            araddr_o   <= '0;
            awvalid_o  <= 1'b0;
            wvalid_o   <= 1'b0;
            bready_o   <= 1'b0;
            arvalid_o  <= 1'b0;
            rready_o   <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (active) wd <= wd + 1'b1;
            if (active && wd_expired) begin
                // Watchdog abort: drop every handshake signal and report.
                state     <= FINISH;
                wd        <= '0;
                done_o    <= 1'b1;
                timeout_o <= 1'b1;
                pass_o    <= 1'b0;
                awvalid_o <= 1'b0;
                wvalid_o  <= 1'b0;
                bready_o  <= 1'b0;
                arvalid_o <= 1'b0;
                rready_o  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start_i) begin
                        state      <= WRITE;
                        wd         <= '0;
                        idx        <= '0;
                        expected   <= seed_i;
                        wdata_o    <= seed_i;
                        awaddr_o   <= '0;
                        awvalid_o  <= 1'b1;
                        wvalid_o   <= 1'b1;
                        busy_o     <= 1'b1;
                        pass_o     <= 1'b0;
                        resp_err_o <= 1'b0;
                        timeout_o  <= 1'b0;
                    end
                    WRITE: begin
                        if (awvalid_o && awready_i) awvalid_o <= 1'b0;
                        if (wvalid_o && wready_i) wvalid_o <= 1'b0;
                        if (!aw_pending && !w_pending) begin
                            state    <= WRESP;
                            wd       <= '0;
                            bready_o <= 1'b1;
                        end
                    end
                    WRESP: if (bready_o && bvalid_i) begin
                        bready_o <= 1'b0;
                        wd       <= '0;
                        if (bresp_i != 2'b00) resp_err_o <= 1'b1;
                        if (idx == IDX_W'(REG_COUNT - 1)) begin
                            state     <= RADDR;
                            araddr_o  <= CRC_ADDR;
                            arvalid_o <= 1'b1;
                        end else begin
                            state     <= WRITE;
                            idx       <= idx_next;
                            wdata_o   <= pat_rot;
                            expected  <= expected ^ pat_rot;
                            awaddr_o  <= ADDR_WIDTH'({idx_next, 2'b00});
                            awvalid_o <= 1'b1;
                            wvalid_o  <= 1'b1;
                        end
                    end
                    RADDR: if (arready_i) begin
                        state     <= RDATA;
                        wd        <= '0;
                        arvalid_o <= 1'b0;
                        rready_o  <= 1'b1;
                    end
                    RDATA: if (rvalid_i) begin
                        state    <= FINISH;
                        wd       <= '0;
                        rready_o <= 1'b0;
                        crc_o    <= rdata_i;
                        pass_o   <= (rdata_i == expected) && !resp_err_o;
                        done_o   <= 1'b1;
                    end
                    FINISH: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_axi_crc_sequencer.sv
// tb_axi_crc_sequencer: directed and randomized passes against a stalling
// register slave model; expectations come from a rotate/XOR reference model.
module tb_axi_crc_sequencer;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int RC = 8;
    localparam int TO = 256;

    logic          clk = 1'b0;
    logic          areset = 1'b0;
    logic          start_i = 1'b0;
    logic [DW-1:0] seed_i = '0;
    logic          busy_o, done_o, pass_o, resp_err_o, timeout_o;
    logic [DW-1:0] crc_o;
    logic [3:0]    awid_o, awlen_o, wid_o, arid_o, wstrb_o;
    logic [2:0]    awsize_o;
    logic [1:0]    awburst_o;
    logic [AW-1:0] awaddr_o, araddr_o;
    logic          awvalid_o, awready_i, wlast_o, wvalid_o, wready_i;
    logic [DW-1:0] wdata_o;
    logic [3:0]    bid_i, rid_i;
    logic [1:0]    bresp_i;
    logic          bvalid_i, bready_o, arvalid_o, arready_i;
    logic [DW-1:0] rdata_i;
    logic          rlast_i, rvalid_i, rready_o;

    axi_crc_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_COUNT(RC), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .areset(areset), .start_i(start_i), .seed_i(seed_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .resp_err_o(resp_err_o),
        .timeout_o(timeout_o), .crc_o(crc_o),
        .awid_o(awid_o), .awlen_o(awlen_o), .awsize_o(awsize_o), .awburst_o(awburst_o),
        .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wid_o(wid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o),
        .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
        .arid_o(arid_o), .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rid_i(rid_i), .rdata_i(rdata_i), .rlast_i(rlast_i), .rvalid_i(rvalid_i),
        .rready_o(rready_o)
    );

    always #5 clk = ~clk;

    int passes = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference model: word k is the seed rotated left by k; CRC is the XOR of all words.
    function automatic logic [31:0] word_k(input logic [31:0] s, input int k);
        if (k == 0) return s;
        return (s << k) | (s >> (32 - k));
    endfunction

    function automatic logic [31:0] crc_model(input logic [31:0] s);
        logic [31:0] x = '0;
        for (int k = 0; k < RC; k++) x ^= word_k(s, k);
        return x;
    endfunction

    // Slave behaviour knobs, driven by the stimulus.
    int aw_delay = 0, w_delay = 0, b_delay = 0, r_delay = 0, err_at = -1;
    bit ar_block = 1'b0;

    // Slave state and logs.
    int          aw_wait, w_wait, b_cnt, r_cnt;
    logic        aw_got, w_got, b_pend, r_pend;
    logic [31:0] aw_addr_q, w_data_q, r_addr;
    logic [1:0]  bresp_pend;
    logic [31:0] mem [0:7];
    logic [31:0] mem_xor;
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    int aw_hs_cnt = 0, w_hs_cnt = 0, b_hs_cnt = 0;
    int viol = 0, done_cnt = 0, ar_hi = 0;

    logic aw_now, w_now, wr_complete;
    logic [31:0] addr_use, data_use;

    assign awready_i   = awvalid_o && (aw_wait >= aw_delay);
    assign wready_i    = wvalid_o && (w_wait >= w_delay);
    assign arready_i   = arvalid_o && !ar_block;
    assign bid_i       = 4'd0;
    assign rid_i       = 4'd0;
    assign rlast_i     = 1'b1;
    assign aw_now      = awvalid_o && awready_i;
    assign w_now       = wvalid_o && wready_i;
    assign wr_complete = (aw_got || aw_now) && (w_got || w_now);
    assign addr_use    = aw_got ? aw_addr_q : awaddr_o;
    assign data_use    = w_got ? w_data_q : wdata_o;

    always_comb begin
        mem_xor = '0;
        for (int i = 0; i < 8; i++) mem_xor ^= mem[i];
    end

    // Register slave: 8 words plus an XOR-CRC location at 0x20, with programmable stalls.
    always @(posedge clk or negedge areset) begin
        if (!areset) begin
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
            aw_wait <= 0; w_wait <= 0; b_cnt <= 0; r_cnt <= 0;
            bvalid_i <= 1'b0; bresp_i <= 2'b00; bresp_pend <= 2'b00;
            rvalid_i <= 1'b0; rdata_i <= '0; r_addr <= '0;
            aw_addr_q <= '0; w_data_q <= '0;
            for (int i = 0; i < 8; i++) mem[i] <= '0;
        end else begin
            aw_wait <= (awvalid_o && !awready_i) ? aw_wait + 1 : 0;
            w_wait  <= (wvalid_o && !wready_i) ? w_wait + 1 : 0;
            if (aw_now) begin aw_got <= 1'b1; aw_addr_q <= awaddr_o; aw_hs_cnt <= aw_hs_cnt + 1; end
            if (w_now) begin w_got <= 1'b1; w_data_q <= wdata_o; w_hs_cnt <= w_hs_cnt + 1; end
            if (wr_complete) begin
                mem[addr_use[4:2]] <= data_use;
                bresp_pend <= (wr_addr_q.size() == err_at) ? 2'b10 : 2'b00;
                wr_addr_q.push_back(addr_use);
                wr_data_q.push_back(data_use);
                aw_got <= 1'b0; w_got <= 1'b0;
                b_pend <= 1'b1; b_cnt <= b_delay;
            end
            if (b_pend && !bvalid_i) begin
                if (b_cnt == 0) begin bvalid_i <= 1'b1; bresp_i <= bresp_pend; end
                else b_cnt <= b_cnt - 1;
            end
            if (bvalid_i && bready_o) begin
                bvalid_i <= 1'b0; bresp_i <= 2'b00; b_pend <= 1'b0; b_hs_cnt <= b_hs_cnt + 1;
            end
            if (arvalid_o && arready_i) begin r_pend <= 1'b1; r_cnt <= r_delay; r_addr <= araddr_o; end
            if (r_pend && !rvalid_i) begin
                if (r_cnt == 0) begin
                    rvalid_i <= 1'b1;
                    rdata_i  <= (r_addr == 32'h20) ? mem_xor : mem[r_addr[4:2]];
                end else r_cnt <= r_cnt - 1;
            end
            if (rvalid_i && rready_o) begin rvalid_i <= 1'b0; r_pend <= 1'b0; end
        end
    end

    // Protocol monitor: done never overlaps a valid/ready, count done pulses and arvalid cycles.
    always @(negedge clk) begin
        if (done_o && (awvalid_o || wvalid_o || arvalid_o || bready_o || rready_o)) viol <= viol + 1;
        if (done_o) done_cnt <= done_cnt + 1;
        if (arvalid_o) ar_hi <= ar_hi + 1;
    end

    task automatic run_pass(input string tag, input logic [31:0] seed, input bit chk_lat,
                            input bit exp_err, input bit exp_to);
        int base, aw0, w0, lat, n;
        base = wr_addr_q.size();
        aw0  = aw_hs_cnt;
        w0   = w_hs_cnt;
        @(negedge clk); start_i = 1'b1; seed_i = seed;
        @(negedge clk); start_i = 1'b0; seed_i = $urandom;
        check({tag, ".busy_rise"}, busy_o, 1);
        check({tag, ".valids_rise"}, {awvalid_o, wvalid_o}, 2'b11);
        lat = 1;
        while (!done_o && lat < 2000) begin @(negedge clk); lat++; end
        check({tag, ".done_seen"}, done_o, 1);
        if (chk_lat) check({tag, ".latency"}, lat, 3 * RC + 4);
        check({tag, ".pass"}, pass_o, !exp_err && !exp_to);
        check({tag, ".resp_err"}, resp_err_o, exp_err);
        check({tag, ".timeout"}, timeout_o, exp_to);
        if (!exp_to) check({tag, ".crc"}, crc_o, crc_model(seed));
        n = wr_addr_q.size() - base;
        check({tag, ".nwrites"}, n, RC);
        check({tag, ".aw_hs"}, aw_hs_cnt - aw0, RC);
        check({tag, ".w_hs"}, w_hs_cnt - w0, RC);
        for (int k = 0; k < n && k < RC; k++) begin
            check({tag, ".waddr"}, wr_addr_q[base + k], 32'(k * 4));
            check({tag, ".wdata"}, wr_data_q[base + k], word_k(seed, k));
        end
        @(negedge clk);
        check({tag, ".done_pulse"}, done_o, 0);
        check({tag, ".busy_fall"}, busy_o, 0);
    endtask

    initial begin
        int d0, b0, a0, n;
        logic [31:0] s;
        repeat (2) @(negedge clk);
        check("rst.outs", {busy_o, done_o, pass_o, resp_err_o, timeout_o}, 5'b0);
        check("rst.valids", {awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o}, 5'b0);
        check("rst.data", {crc_o, awaddr_o, araddr_o, wdata_o}, 128'b0);
        areset = 1'b1;
        @(negedge clk);

        run_pass("seed1", 32'h1, 1'b1, 1'b0, 1'b0);
        check("seed1.crc_lit", crc_o, 32'h000000FF);
        check("seed1.araddr", araddr_o, 32'h20);

        run_pass("seedmsb", 32'h80000001, 1'b1, 1'b0, 1'b0);
        check("seedmsb.crc_lit", crc_o, 32'h80000080);

        aw_delay = 0; w_delay = 3; b_delay = 5;
        run_pass("stall", 32'h1, 1'b0, 1'b0, 1'b0);
        check("stall.crc_lit", crc_o, 32'h000000FF);
        w_delay = 0; b_delay = 0;

        err_at = wr_addr_q.size() + 2;
        run_pass("berr", 32'h1234_5678, 1'b1, 1'b1, 1'b0);
        err_at = -1;

        ar_block = 1'b1;
        a0 = ar_hi;
        run_pass("tmo", 32'hCAFE_0001, 1'b0, 1'b0, 1'b1);
        check("tmo.arvalid_drop", arvalid_o, 0);
        check("tmo.ar_cycles", ar_hi - a0, TO);
        ar_block = 1'b0;
        run_pass("after_tmo", 32'h0F0F_0F0F, 1'b1, 1'b0, 1'b0);

        d0 = done_cnt; b0 = b_hs_cnt;
        @(negedge clk); start_i = 1'b1; seed_i = 32'hDEAD_BEEF;
        @(negedge clk); start_i = 1'b0;
        n = 0;
        while (!((b_hs_cnt - b0) == 3 && bready_o) && n < 200) begin @(negedge clk); n++; end
        check("rst_mid.reach_wresp4", {bready_o, 8'(b_hs_cnt - b0)}, {1'b1, 8'd3});
        areset = 1'b0;
        #1;
        check("rst_mid.outs", {busy_o, done_o, pass_o, resp_err_o, timeout_o}, 5'b0);
        check("rst_mid.valids", {awvalid_o, wvalid_o, bready_o, arvalid_o, rready_o}, 5'b0);
        check("rst_mid.data", {crc_o, awaddr_o, araddr_o, wdata_o}, 128'b0);
        @(negedge clk); areset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mid.no_done", done_cnt - d0, 0);
        run_pass("after_rst", 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0);

        for (int p = 0; p < 4; p++) begin
            s        = $urandom;
            aw_delay = $urandom_range(0, 3);
            w_delay  = $urandom_range(0, 4);
            b_delay  = $urandom_range(0, 5);
            r_delay  = $urandom_range(0, 2);
            if ($urandom_range(0, 1) == 1) err_at = wr_addr_q.size() + $urandom_range(0, RC - 1);
            else err_at = -1;
            run_pass("rand", s, 1'b0, err_at >= 0, 1'b0);
        end
        err_at = -1;

        check("done_vs_valid_overlap", viol, 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
